// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB walk over a shared memory port, sticky HALT on bad encodings.
// Latency: j 2, beq 3, R-type/addiu/sw 4, lw 5 cycles; each mem_ready=0 cycle in FETCH or MEM adds one.
// Backpressure: FETCH and MEM hold their request until mem_ready; mem_ready is ignored in every other state.
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [2:0]  state,
   output logic        memread,
   output logic        memwrite,
   output logic        iord,
   output logic        irwrite,
   output logic        pcwrite,
   output logic [1:0]  pcsrc,
   output logic        alusrcbimm,
   output logic [2:0]  alucontrol,
   output logic        memtoreg,
   output logic        regwrite,
   output logic [4:0]  destreg,
   output logic        illegal
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADDU  = 3'b101;
   localparam logic [2:0] ALU_SUBU  = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b111;
   localparam logic [2:0] ALU_OR    = 3'b110;
   localparam logic [2:0] ALU_SLTU  = 3'b000;
   localparam logic [2:0] ALU_UNDEF = 3'b010;

   state_t      state_q, state_d;
   logic        illegal_q, illegal_d;

   logic [5:0]  opcode, funct;
   logic        is_rtype, is_lw, is_sw, is_beq, is_addiu, is_j;
   logic        dec_valid;
   logic [2:0]  dec_alu;
   logic        dec_bimm;
   logic [4:0]  dec_dst;
   logic        in_body;

   logic        memread_c, memwrite_c, iord_c, irwrite_c, pcwrite_c;
   logic        memtoreg_c, regwrite_c;
   logic [1:0]  pcsrc_c;

   // rs and shamt fields are datapath-only; the controller never looks at them
   logic        unused_instr_bits;
   assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

   assign opcode   = instr[31:26];
   assign funct    = instr[5:0];
   assign is_rtype = (opcode == OP_RTYPE);
   assign is_lw    = (opcode == OP_LW);
   assign is_sw    = (opcode == OP_SW);
   assign is_beq   = (opcode == OP_BEQ);
   assign is_addiu = (opcode == OP_ADDIU);
   assign is_j     = (opcode == OP_J);
   assign dec_dst  = is_rtype ? instr[15:11] : instr[20:16];

   // Instruction decode: ALU op, operand-B select and legality of the current encoding
   always_comb begin
      dec_valid = 1'b0;
      dec_alu   = ALU_UNDEF;
      dec_bimm  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               6'b100001: begin dec_alu = ALU_ADDU; dec_valid = 1'b1; end
               6'b100011: begin dec_alu = ALU_SUBU; dec_valid = 1'b1; end
               6'b100100: begin dec_alu = ALU_AND;  dec_valid = 1'b1; end
               6'b100101: begin dec_alu = ALU_OR;   dec_valid = 1'b1; end
               6'b101011: begin dec_alu = ALU_SLTU; dec_valid = 1'b1; end
               default:   dec_valid = 1'b0;
            endcase
         end
         OP_LW, OP_SW, OP_ADDIU: begin
            dec_alu   = ALU_ADDU;
            dec_bimm  = 1'b1;
            dec_valid = 1'b1;
         end
         OP_BEQ:  begin dec_alu = ALU_SUBU; dec_valid = 1'b1; end
         OP_J:    dec_valid = 1'b1;
         default: dec_valid = 1'b0;
      endcase
   end

   // Next-state and raw per-cycle strobes for the current state
   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      memread_c  = 1'b0;
      memwrite_c = 1'b0;
      iord_c     = 1'b0;
      irwrite_c  = 1'b0;
      pcwrite_c  = 1'b0;
      pcsrc_c    = 2'b00;
      memtoreg_c = 1'b0;
      regwrite_c = 1'b0;
      case (state_q)
         S_FETCH: begin
            memread_c = 1'b1;
            if (mem_ready) begin
               irwrite_c = 1'b1;
               pcwrite_c = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!dec_valid) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else if (is_j) begin
               pcwrite_c = 1'b1;
               pcsrc_c   = 2'b10;
               state_d   = S_FETCH;
            end else begin
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_rtype || is_addiu) begin
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else if (is_beq) begin
               pcwrite_c = zero;
               pcsrc_c   = 2'b01;
               state_d   = S_FETCH;
            end else begin
               state_d   = S_HALT;
            end
         end
         S_MEM: begin
            iord_c     = 1'b1;
            memread_c  = is_lw;
            memwrite_c = is_sw;
            if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
         end
         S_WB: begin
            regwrite_c = 1'b1;
            memtoreg_c = is_lw;
            state_d    = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   // State and sticky illegal flag; reset returns to FETCH immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Decoded fields are only meaningful while an instruction is in flight
   assign in_body = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);

   assign state      = state_q;
   assign illegal    = illegal_q;
   assign alucontrol = in_body ? dec_alu  : ALU_UNDEF;
   assign alusrcbimm = in_body ? dec_bimm : 1'b0;
   assign destreg    = in_body ? dec_dst  : 5'd0;

   // Strobes are killed while reset is held so no write half-completes
   assign memread  = memread_c  & reset;
   assign memwrite = memwrite_c & reset;
   assign iord     = iord_c     & reset;
   assign irwrite  = irwrite_c  & reset;
   assign pcwrite  = pcwrite_c  & reset;
   assign memtoreg = memtoreg_c & reset;
   assign regwrite = regwrite_c & reset;
   assign pcsrc    = reset ? pcsrc_c : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle vector table plus randomised lw stall sequences.
// Latency: expected outputs are compared in the same cycle the inputs are applied.
// Backpressure: mem_ready stalls are driven from the table and from random stall counts.
module tb_multicycle_controller;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic [2:0]  state;
   logic        memread, memwrite, iord, irwrite, pcwrite;
   logic [1:0]  pcsrc;
   logic        alusrcbimm;
   logic [2:0]  alucontrol;
   logic        memtoreg, regwrite;
   logic [4:0]  destreg;
   logic        illegal;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .state(state), .memread(memread), .memwrite(memwrite), .iord(iord),
      .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrcbimm(alusrcbimm),
      .alucontrol(alucontrol), .memtoreg(memtoreg), .regwrite(regwrite),
      .destreg(destreg), .illegal(illegal)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] I_ADDU  = 32'h00221821; // addu $3,$1,$2
   localparam logic [31:0] I_ADDIU = 32'h24240005; // addiu $4,$1,5
   localparam logic [31:0] I_SLTU  = 32'h0022382B; // sltu $7,$1,$2
   localparam logic [31:0] I_LW    = 32'h8C050008; // lw $5,8($0)
   localparam logic [31:0] I_SW    = 32'hAC060004; // sw $6,4($0)
   localparam logic [31:0] I_BEQ   = 32'h10220003; // beq $1,$2,3
   localparam logic [31:0] I_J     = 32'h08000010; // j 0x40
   localparam logic [31:0] I_BADOP = 32'hFC000000; // opcode 0x3F
   localparam logic [31:0] I_BADFN = 32'h00221820; // R-type funct 0x20

   // strobe groups {memread, memwrite, iord, irwrite, pcwrite, regwrite}
   localparam logic [5:0] SB_NO = 6'b000000;
   localparam logic [5:0] SB_F1 = 6'b100110;
   localparam logic [5:0] SB_F0 = 6'b100000;
   localparam logic [5:0] SB_RD = 6'b101000;
   localparam logic [5:0] SB_WR = 6'b011000;
   localparam logic [5:0] SB_PC = 6'b000010;
   localparam logic [5:0] SB_RW = 6'b000001;
   localparam logic [2:0] UND   = 3'b010;

   typedef struct {
      logic        rst_n;
      logic [31:0] instr;
      logic        zero;
      logic        rdy;
      logic [21:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [21:0] sb_q[$];
   int          cyc_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   function automatic void add(logic r, logic [31:0] i, logic z, logic rd,
                               logic [2:0] st, logic [5:0] sb, logic [1:0] ps, logic bi,
                               logic [2:0] al, logic mt, logic [4:0] ds, logic il);
      vec_t v;
      v.rst_n = r;
      v.instr = i;
      v.zero  = z;
      v.rdy   = rd;
      v.exp   = {st, sb[5:1], ps, bi, al, mt, sb[0], ds, il};
      vecs.push_back(v);
   endfunction

   function automatic logic [21:0] act();
      return {state, memread, memwrite, iord, irwrite, pcwrite, pcsrc, alusrcbimm,
              alucontrol, memtoreg, regwrite, destreg, illegal};
   endfunction

   task automatic check(string name, logic [21:0] got, logic [21:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%06h want=%06h", name, got, want);
   endtask

   task automatic check_int(string name, int got, int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s got=%0d want=%0d", name, got, want);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  sf, sm, fc, mc, n, rw_cnt, ir_cnt;
      bit  done, overlap;

      // reset held
      add(0, 32'd0, 0, 1,  0, SB_NO, 2'b00, 0, UND,    0, 5'd0, 0);
      add(0, 32'd0, 0, 1,  0, SB_NO, 2'b00, 0, UND,    0, 5'd0, 0);
      // addu
      add(1, I_ADDU, 0, 1,  0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_ADDU, 0, 1,  1, SB_NO, 2'b00, 0, 3'b101, 0, 5'd3, 0);
      add(1, I_ADDU, 0, 1,  2, SB_NO, 2'b00, 0, 3'b101, 0, 5'd3, 0);
      add(1, I_ADDU, 0, 1,  4, SB_RW, 2'b00, 0, 3'b101, 0, 5'd3, 0);
      // addiu
      add(1, I_ADDIU, 0, 1, 0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_ADDIU, 0, 1, 1, SB_NO, 2'b00, 1, 3'b101, 0, 5'd4, 0);
      add(1, I_ADDIU, 0, 1, 2, SB_NO, 2'b00, 1, 3'b101, 0, 5'd4, 0);
      add(1, I_ADDIU, 0, 1, 4, SB_RW, 2'b00, 1, 3'b101, 0, 5'd4, 0);
      // sltu
      add(1, I_SLTU, 0, 1,  0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_SLTU, 0, 1,  1, SB_NO, 2'b00, 0, 3'b000, 0, 5'd7, 0);
      add(1, I_SLTU, 0, 1,  2, SB_NO, 2'b00, 0, 3'b000, 0, 5'd7, 0);
      add(1, I_SLTU, 0, 1,  4, SB_RW, 2'b00, 0, 3'b000, 0, 5'd7, 0);
      // lw with two stall cycles in MEM: 7 cycles total
      add(1, I_LW, 0, 1,    0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_LW, 0, 1,    1, SB_NO, 2'b00, 1, 3'b101, 0, 5'd5, 0);
      add(1, I_LW, 0, 1,    2, SB_NO, 2'b00, 1, 3'b101, 0, 5'd5, 0);
      add(1, I_LW, 0, 0,    3, SB_RD, 2'b00, 1, 3'b101, 0, 5'd5, 0);
      add(1, I_LW, 0, 0,    3, SB_RD, 2'b00, 1, 3'b101, 0, 5'd5, 0);
      add(1, I_LW, 0, 1,    3, SB_RD, 2'b00, 1, 3'b101, 0, 5'd5, 0);
      add(1, I_LW, 0, 1,    4, SB_RW, 2'b00, 1, 3'b101, 1, 5'd5, 0);
      // sw with one stall cycle in FETCH
      add(1, I_SW, 0, 0,    0, SB_F0, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_SW, 0, 1,    0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_SW, 0, 1,    1, SB_NO, 2'b00, 1, 3'b101, 0, 5'd6, 0);
      add(1, I_SW, 0, 1,    2, SB_NO, 2'b00, 1, 3'b101, 0, 5'd6, 0);
      add(1, I_SW, 0, 1,    3, SB_WR, 2'b00, 1, 3'b101, 0, 5'd6, 0);
      // beq taken
      add(1, I_BEQ, 1, 1,   0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_BEQ, 1, 1,   1, SB_NO, 2'b00, 0, 3'b001, 0, 5'd2, 0);
      add(1, I_BEQ, 1, 1,   2, SB_PC, 2'b01, 0, 3'b001, 0, 5'd2, 0);
      // beq not taken; mem_ready low outside FETCH/MEM must not stall
      add(1, I_BEQ, 0, 1,   0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_BEQ, 1, 0,   1, SB_NO, 2'b00, 0, 3'b001, 0, 5'd2, 0);
      add(1, I_BEQ, 0, 0,   2, SB_NO, 2'b01, 0, 3'b001, 0, 5'd2, 0);
      // j
      add(1, I_J, 0, 1,     0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_J, 0, 1,     1, SB_PC, 2'b10, 0, UND,    0, 5'd0, 0);
      // unsupported opcode: HALT for 10 cycles, then reset
      add(1, I_BADOP, 0, 1, 0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_BADOP, 0, 1, 1, SB_NO, 2'b00, 0, UND,    0, 5'd0, 0);
      for (int k = 0; k < 10; k++)
         add(1, I_BADOP, k[0], k[0], 5, SB_NO, 2'b00, 0, UND, 0, 5'd0, 1);
      add(0, I_BADOP, 0, 1, 0, SB_NO, 2'b00, 0, UND,    0, 5'd0, 0);
      // unsupported R-type funct
      add(1, I_BADFN, 0, 1, 0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_BADFN, 0, 1, 1, SB_NO, 2'b00, 0, UND,    0, 5'd3, 0);
      add(1, I_BADFN, 0, 1, 5, SB_NO, 2'b00, 0, UND,    0, 5'd0, 1);
      add(1, I_BADFN, 0, 1, 5, SB_NO, 2'b00, 0, UND,    0, 5'd0, 1);
      add(0, I_BADFN, 0, 1, 0, SB_NO, 2'b00, 0, UND,    0, 5'd0, 0);
      // sw interrupted by reset while the write is pending
      add(1, I_SW, 0, 1,    0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_SW, 0, 1,    1, SB_NO, 2'b00, 1, 3'b101, 0, 5'd6, 0);
      add(1, I_SW, 0, 1,    2, SB_NO, 2'b00, 1, 3'b101, 0, 5'd6, 0);
      add(1, I_SW, 0, 0,    3, SB_WR, 2'b00, 1, 3'b101, 0, 5'd6, 0);
      add(0, I_SW, 0, 1,    0, SB_NO, 2'b00, 0, UND,    0, 5'd0, 0);
      add(0, I_SW, 0, 1,    0, SB_NO, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_ADDU, 0, 0,  0, SB_F0, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_ADDU, 0, 1,  0, SB_F1, 2'b00, 0, UND,    0, 5'd0, 0);
      add(1, I_ADDU, 0, 1,  1, SB_NO, 2'b00, 0, 3'b101, 0, 5'd3, 0);
      add(1, I_ADDU, 0, 1,  2, SB_NO, 2'b00, 0, 3'b101, 0, 5'd3, 0);
      add(1, I_ADDU, 0, 1,  4, SB_RW, 2'b00, 0, 3'b101, 0, 5'd3, 0);

      // apply each row after the edge, compare before the next edge
      for (int k = 0; k < vecs.size(); k++) begin
         @(posedge clk); #1;
         reset     = vecs[k].rst_n;
         instr     = vecs[k].instr;
         zero      = vecs[k].zero;
         mem_ready = vecs[k].rdy;
         sb_q.push_back(vecs[k].exp);
         @(negedge clk);
         check($sformatf("vec%0d", k), act(), sb_q.pop_front());
      end

      // lw with random stalls in FETCH and MEM: 5 cycles plus one per stall
      for (int t = 0; t < 3; t++) begin
         sf = $urandom_range(0, 3);
         sm = $urandom_range(0, 3);
         cyc_q.push_back(5 + sf + sm);
         fc = 0; mc = 0; n = 0; rw_cnt = 0; ir_cnt = 0;
         done = 1'b0; overlap = 1'b0;
         instr = I_LW;
         zero  = 1'b0;
         while (!done && n < 40) begin
            @(posedge clk); #1;
            if (state == 3'd0 && fc < sf) begin
               mem_ready = 1'b0; fc++;
            end else if (state == 3'd3 && mc < sm) begin
               mem_ready = 1'b0; mc++;
            end else begin
               mem_ready = 1'b1;
            end
            @(negedge clk);
            n++;
            if (memread && memwrite) overlap = 1'b1;
            if (regwrite) rw_cnt++;
            if (irwrite) ir_cnt++;
            if (state == 3'd4) done = 1'b1;
         end
         check_int($sformatf("lw_cycles%0d", t), n, cyc_q.pop_front());
         check_int($sformatf("lw_regwrite_cnt%0d", t), rw_cnt, 1);
         check_int($sformatf("lw_irwrite_cnt%0d", t), ir_cnt, 1);
         check_int($sformatf("lw_rd_wr_overlap%0d", t), int'(overlap), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
